// File: rtl/ball_pixel_renderer_pkg.sv
// Shared types and constants for the ball pixel renderer (package sprite_pkg).
// Optional outline output is controlled by the BALL_OUTLINE_EN macro in the other files.
package sprite_pkg;

    localparam int COORD_W     = 10;
    localparam int SPRITE_DIM  = 127;
    localparam int SPRITE_HALF = 63;

    typedef logic [SPRITE_DIM-1:0][SPRITE_DIM-1:0] sprite_t;
    typedef logic [SPRITE_DIM-1:0]                 sprite_row_t;
    typedef logic [COORD_W-1:0]                    coord_t;
    typedef logic signed [COORD_W+1:0]             offset_t;
    typedef logic [6:0]                            sprite_idx_t;

    localparam offset_t OFF_ZERO = offset_t'(0);
    localparam offset_t OFF_HALF = offset_t'(SPRITE_HALF);
    localparam offset_t OFF_MAX  = offset_t'(SPRITE_DIM - 1);

    // True when a signed sprite offset addresses a real sprite row/column.
    function automatic logic in_sprite(input offset_t v);
        return (v >= OFF_ZERO) && (v <= OFF_MAX);
    endfunction

    // Signed distance from the ball centre re-based onto sprite indices.
    function automatic offset_t sprite_offset(input coord_t pix, input coord_t centre);
        return offset_t'({2'b00, pix}) - offset_t'({2'b00, centre}) + OFF_HALF;
    endfunction

endpackage

// File: rtl/ball_pixel_renderer_if.sv
// Pixel request / hit result bundle between the raster timing logic and the renderer.
// With BALL_OUTLINE_EN defined an extra edge_hit result is carried.
interface ball_pixel_renderer_if;
    import sprite_pkg::*;

    logic   pix_valid;
    coord_t pix_row;
    coord_t pix_col;
    logic   hit_valid;
    logic   hit;
    coord_t hit_row;
    coord_t hit_col;
`ifdef BALL_OUTLINE_EN
    logic   edge_hit;
`endif

    modport master (
        output pix_valid, pix_row, pix_col,
`ifdef BALL_OUTLINE_EN
        input  edge_hit,
`endif
        input  hit_valid, hit, hit_row, hit_col
    );

    modport slave (
        input  pix_valid, pix_row, pix_col,
`ifdef BALL_OUTLINE_EN
        output edge_hit,
`endif
        output hit_valid, hit, hit_row, hit_col
    );

endinterface

// File: rtl/ball_shadow_regs.sv
// Per-frame shadow copy of ball enable, centre and sprite, loaded on frame_start
// so the drawn ball cannot tear mid-frame.
module ball_shadow_regs
    import sprite_pkg::*;
(
    input  logic    clock,
    input  logic    reset_L,
    input  logic    frame_start,
    input  logic    ball_en,
    input  coord_t  ball_x,
    input  coord_t  ball_y,
    input  sprite_t sprite,
    output logic    sh_en_r,
    output coord_t  sh_x_r,
    output coord_t  sh_y_r,
    output sprite_t sh_sprite_r
);

    // Capture on frame_start, hold otherwise.
    always_ff @(posedge clock) begin
        if (!reset_L) begin
            sh_en_r     <= 1'b0;
            sh_x_r      <= {COORD_W{1'b0}};
            sh_y_r      <= {COORD_W{1'b0}};
            sh_sprite_r <= {(SPRITE_DIM*SPRITE_DIM){1'b0}};
        end else if (frame_start) begin
            sh_en_r     <= ball_en;
            sh_x_r      <= ball_x;
            sh_y_r      <= ball_y;
            sh_sprite_r <= sprite;
        end else begin
            sh_en_r     <= sh_en_r;
            sh_x_r      <= sh_x_r;
            sh_y_r      <= sh_y_r;
            sh_sprite_r <= sh_sprite_r;
        end
    end

endmodule

// File: rtl/ball_pixel_renderer.sv
// Two-stage "pixel inside ball" lookup: stage 1 fetches the sprite row, stage 2 picks the bit.
// BALL_OUTLINE_EN adds neighbour rows and an edge_hit result for drawing the ball outline.
module ball_pixel_renderer
    import sprite_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_L,
    input  logic                  frame_start,
    input  logic                  ball_en,
    input  coord_t                ball_x,
    input  coord_t                ball_y,
    input  sprite_t               sprite,
    ball_pixel_renderer_if.slave  pix
);

    logic    sh_en_r;
    coord_t  sh_x_r;
    coord_t  sh_y_r;
    sprite_t sh_sprite_r;

    ball_shadow_regs u_shadow (
        .clock       (clock),
        .reset_L     (reset_L),
        .frame_start (frame_start),
        .ball_en     (ball_en),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .sprite      (sprite),
        .sh_en_r     (sh_en_r),
        .sh_x_r      (sh_x_r),
        .sh_y_r      (sh_y_r),
        .sh_sprite_r (sh_sprite_r)
    );

    offset_t     dr_s;
    offset_t     dc_s;
    logic        in_box_s;
    sprite_idx_t dr_idx_s;
    sprite_idx_t dc_idx_s;
    sprite_row_t row_s;
    logic        hit_s;

    logic        s1_valid_r;
    sprite_row_t s1_row_r;
    sprite_idx_t s1_dc_r;
    coord_t      s1_pix_row_r;
    coord_t      s1_pix_col_r;

`ifdef BALL_OUTLINE_EN
    sprite_row_t row_up_s;
    sprite_row_t row_dn_s;
    sprite_row_t s1_row_up_r;
    sprite_row_t s1_row_dn_r;
    logic        edge_s;
`endif

    // Stage-1 address generation; out-of-box pixels read an all-zero row at column 0.
    always_comb begin
        dr_s     = sprite_offset(pix.pix_row, sh_y_r);
        dc_s     = sprite_offset(pix.pix_col, sh_x_r);
        in_box_s = sh_en_r && in_sprite(dr_s) && in_sprite(dc_s);
        dr_idx_s = 7'd0;
        dc_idx_s = 7'd0;
        row_s    = {SPRITE_DIM{1'b0}};
`ifdef BALL_OUTLINE_EN
        row_up_s = {SPRITE_DIM{1'b0}};
        row_dn_s = {SPRITE_DIM{1'b0}};
`endif
        if (in_box_s) begin
            dr_idx_s = dr_s[6:0];
            dc_idx_s = dc_s[6:0];
            row_s    = sh_sprite_r[dr_idx_s];
`ifdef BALL_OUTLINE_EN
            if (dr_idx_s != 7'd0) begin
                row_up_s = sh_sprite_r[dr_idx_s - 7'd1];
            end else begin
                row_up_s = {SPRITE_DIM{1'b0}};
            end
            if (dr_idx_s != 7'(SPRITE_DIM - 1)) begin
                row_dn_s = sh_sprite_r[dr_idx_s + 7'd1];
            end else begin
                row_dn_s = {SPRITE_DIM{1'b0}};
            end
`endif
        end else begin
            row_s = {SPRITE_DIM{1'b0}};
        end
    end

    // Stage-2 bit select (and outline test when enabled).
    always_comb begin
        hit_s = s1_valid_r & s1_row_r[s1_dc_r];
`ifdef BALL_OUTLINE_EN
        edge_s = 1'b0;
        if (hit_s) begin
            edge_s = !((s1_dc_r != 7'd0) && s1_row_r[s1_dc_r - 7'd1])
                  || !((s1_dc_r != 7'(SPRITE_DIM - 1)) && s1_row_r[s1_dc_r + 7'd1])
                  || !s1_row_up_r[s1_dc_r]
                  || !s1_row_dn_r[s1_dc_r];
        end else begin
            edge_s = 1'b0;
        end
`endif
    end

    // Pipeline registers; echoes only move with valid data so they hold across gaps.
    always_ff @(posedge clock) begin
        if (!reset_L) begin
            s1_valid_r    <= 1'b0;
            s1_row_r      <= {SPRITE_DIM{1'b0}};
            s1_dc_r       <= 7'd0;
            s1_pix_row_r  <= {COORD_W{1'b0}};
            s1_pix_col_r  <= {COORD_W{1'b0}};
            pix.hit_valid <= 1'b0;
            pix.hit       <= 1'b0;
            pix.hit_row   <= {COORD_W{1'b0}};
            pix.hit_col   <= {COORD_W{1'b0}};
`ifdef BALL_OUTLINE_EN
            s1_row_up_r   <= {SPRITE_DIM{1'b0}};
            s1_row_dn_r   <= {SPRITE_DIM{1'b0}};
            pix.edge_hit  <= 1'b0;
`endif
        end else begin
            s1_valid_r    <= pix.pix_valid;
            s1_row_r      <= row_s;
            s1_dc_r       <= dc_idx_s;
            pix.hit_valid <= s1_valid_r;
            pix.hit       <= hit_s;
`ifdef BALL_OUTLINE_EN
            s1_row_up_r   <= row_up_s;
            s1_row_dn_r   <= row_dn_s;
            pix.edge_hit  <= edge_s;
`endif
            if (pix.pix_valid) begin
                s1_pix_row_r <= pix.pix_row;
                s1_pix_col_r <= pix.pix_col;
            end
            if (s1_valid_r) begin
                pix.hit_row <= s1_pix_row_r;
                pix.hit_col <= s1_pix_col_r;
            end
        end
    end

endmodule

// File: tb/tb_ball_pixel_renderer.sv
// Directed bench for ball_pixel_renderer; edge_hit checks compile in with BALL_OUTLINE_EN.
module tb_ball_pixel_renderer;
    import sprite_pkg::*;

    logic    clock = 1'b0;
    logic    reset_L;
    logic    frame_start;
    logic    ball_en;
    coord_t  ball_x;
    coord_t  ball_y;
    sprite_t sprite;

    int n_assert = 0;
    int n_fail   = 0;

    logic   prev_v;
    coord_t prev_col;

    ball_pixel_renderer_if pix_bus ();

    ball_pixel_renderer dut (
        .clock       (clock),
        .reset_L     (reset_L),
        .frame_start (frame_start),
        .ball_en     (ball_en),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .sprite      (sprite),
        .pix         (pix_bus.slave)
    );

    always #5 clock = ~clock;

    function automatic sprite_t make_circle(input int r);
        sprite_t s;
        for (int i = 0; i < SPRITE_DIM; i++) begin
            for (int j = 0; j < SPRITE_DIM; j++) begin
                s[i][j] = ((i - 63) * (i - 63) + (j - 63) * (j - 63)) < (r * r);
            end
        end
        return s;
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load(input logic en, input int x, input int y);
        ball_en     = en;
        ball_x      = coord_t'(x);
        ball_y      = coord_t'(y);
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
    endtask

    task automatic probe(input string tag, input int row, input int col, input logic exp_hit);
        pix_bus.pix_valid = 1'b1;
        pix_bus.pix_row   = coord_t'(row);
        pix_bus.pix_col   = coord_t'(col);
        cyc();
        pix_bus.pix_valid = 1'b0;
        cyc();
        check({tag, "_valid"}, pix_bus.hit_valid, 1'b1);
        check({tag, "_hit"},   pix_bus.hit,       exp_hit);
        check({tag, "_row"},   pix_bus.hit_row,   coord_t'(row));
        check({tag, "_col"},   pix_bus.hit_col,   coord_t'(col));
    endtask

    // One stream cycle: present (v,col) on row 100, then check the item from two cycles back.
    task automatic stream_step(input logic v, input int col);
        pix_bus.pix_valid = v;
        pix_bus.pix_row   = 10'd100;
        pix_bus.pix_col   = coord_t'(col);
        cyc();
        check("stream_valid", pix_bus.hit_valid, prev_v);
        if (prev_v) begin
            check("stream_hit", pix_bus.hit, (prev_col >= 10'd91) && (prev_col <= 10'd109));
            check("stream_row", pix_bus.hit_row, 10'd100);
            check("stream_col", pix_bus.hit_col, prev_col);
        end else begin
            check("stream_gap_hit", pix_bus.hit, 1'b0);
        end
        prev_v   = v;
        prev_col = coord_t'(col);
    endtask

    initial begin
        reset_L           = 1'b0;
        frame_start       = 1'b0;
        ball_en           = 1'b0;
        ball_x            = 10'd0;
        ball_y            = 10'd0;
        sprite            = make_circle(10);
        pix_bus.pix_valid = 1'b0;
        pix_bus.pix_row   = 10'd0;
        pix_bus.pix_col   = 10'd0;
        cyc();
        cyc();
        check("rst_hit_valid", pix_bus.hit_valid, 1'b0);
        check("rst_hit",       pix_bus.hit,       1'b0);
        check("rst_hit_row",   pix_bus.hit_row,   10'd0);
        check("rst_hit_col",   pix_bus.hit_col,   10'd0);
        reset_L = 1'b1;
        cyc();

        // Ball of radius 10 centred at (100,100)
        load(1'b1, 100, 100);
        probe("centre",      100, 100, 1'b1);
        probe("row110",      110, 100, 1'b0);
        probe("row109",      109, 100, 1'b1);
        probe("col109",      100, 109, 1'b1);
        probe("col110",      100, 110, 1'b0);
        probe("box_top",      37, 100, 1'b0);
        probe("above_box",    36, 100, 1'b0);
        probe("origin_far",    0,   0, 1'b0);

        // Ball hanging off the top-left corner
        load(1'b1, 5, 5);
        probe("corner_00",     0,    0, 1'b1);
        probe("no_wrap",       0, 1023, 1'b0);

        // Shadow coherence
        load(1'b1, 100, 100);
        ball_x = 10'd300;
        probe("no_fs_change", 100, 100, 1'b1);
        pix_bus.pix_valid = 1'b1;
        pix_bus.pix_row   = 10'd100;
        pix_bus.pix_col   = 10'd100;
        frame_start       = 1'b1;
        cyc();
        frame_start       = 1'b0;
        pix_bus.pix_col   = 10'd300;
        cyc();
        pix_bus.pix_valid = 1'b0;
        check("same_edge_hit", pix_bus.hit,     1'b1);
        check("same_edge_col", pix_bus.hit_col, 10'd100);
        cyc();
        check("new_centre_valid", pix_bus.hit_valid, 1'b1);
        check("new_centre_hit",   pix_bus.hit,       1'b1);
        check("new_centre_col",   pix_bus.hit_col,   10'd300);
        probe("old_centre_miss", 100, 100, 1'b0);

        // Row-100 stream with random gaps
        load(1'b1, 100, 100);
        prev_v   = 1'b0;
        prev_col = 10'd0;
        for (int c = 0; c < 640; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                stream_step(1'b0, 0);
            end
            stream_step(1'b1, c);
        end
        stream_step(1'b0, 0);
        stream_step(1'b0, 0);
        check("hold_row", pix_bus.hit_row, 10'd100);
        check("hold_col", pix_bus.hit_col, 10'd639);

        // Reset in the middle of traffic
        pix_bus.pix_valid = 1'b1;
        pix_bus.pix_row   = 10'd100;
        pix_bus.pix_col   = 10'd100;
        cyc();
        reset_L = 1'b0;
        cyc();
        reset_L           = 1'b1;
        pix_bus.pix_valid = 1'b0;
        check("mid_rst_valid0", pix_bus.hit_valid, 1'b0);
        check("mid_rst_col",    pix_bus.hit_col,   10'd0);
        cyc();
        check("mid_rst_valid1", pix_bus.hit_valid, 1'b0);
        check("mid_rst_hit",    pix_bus.hit,       1'b0);
        probe("post_rst", 100, 100, 1'b0);

`ifdef BALL_OUTLINE_EN
        load(1'b1, 100, 100);
        probe("outline_rim", 100, 109, 1'b1);
        check("edge_rim", pix_bus.edge_hit, 1'b1);
        probe("outline_mid", 100, 100, 1'b1);
        check("edge_mid", pix_bus.edge_hit, 1'b0);
        cyc();
        check("edge_idle", pix_bus.edge_hit, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ball_pixel_renderer.md
Name: ball_pixel_renderer

Overview:
- Downstream consumer of the combinational circle-sprite generator. It takes the 127x127 sprite bitmap plus a ball centre and answers "is this screen pixel inside the ball" for a raster pixel stream from the VGA timing logic.
- Ball position and sprite are captured once per frame into shadow registers, so the drawn ball never tears mid-frame.
- The lookup is a 2-stage pipeline that accepts one pixel per cycle.

Parameters:
- COORD_W, 10, width of screen row/column coordinates (unsigned).
- SPRITE_DIM, 127, sprite side length in pixels.
- SPRITE_HALF, 63, sprite centre index; must equal (SPRITE_DIM-1)/2.

Ports:
- clock  in  1  system clock
- reset_L  in  1  synchronous active-low reset
- frame_start  in  1  single-cycle pulse at start of vertical blank; loads the shadow registers
- ball_en  in  1  ball visible this frame (sampled on frame_start)
- ball_x  in  COORD_W  ball centre column (sampled on frame_start)
- ball_y  in  COORD_W  ball centre row (sampled on frame_start)
- sprite  in  [SPRITE_DIM-1:0][SPRITE_DIM-1:0]  circle bitmap; sprite[i][j] is row i, column j (sampled on frame_start)
- pix_valid  in  1  pixel request valid
- pix_row  in  COORD_W  requested pixel row
- pix_col  in  COORD_W  requested pixel column
- hit_valid  out  1  result valid
- hit  out  1  pixel lies inside the ball
- hit_row  out  COORD_W  echo of pix_row
- hit_col  out  COORD_W  echo of pix_col

Behaviour:
- Clock and reset: single clock `clock`. Reset `reset_L` is synchronous and active-low; all state is cleared on the clock edge where reset_L=0.
- Reset values: shadow en=0, shadow x/y=0, shadow sprite all zeros; all pipeline valids 0; hit_valid=0, hit=0, hit_row=0, hit_col=0.
- Shadow load: on a clock edge with frame_start=1, the shadow registers capture ball_en, ball_x, ball_y and sprite. With frame_start=0 they hold; input changes have no effect.
- Stage 1 (the edge after the request):
  - dr = pix_row - sh_y + SPRITE_HALF and dc = pix_col - sh_x + SPRITE_HALF, computed signed at COORD_W+2 bits. No wrap-around is permitted.
  - in_box = sh_en && 0<=dr<=SPRITE_DIM-1 && 0<=dc<=SPRITE_DIM-1.
  - Register the row: row_q = in_box ? sh_sprite[dr] : 0. Also register dc (7 bits), the coordinates and valid.
- Stage 2 (the next edge): hit = row_q[dc]; hit_valid = stage-1 valid.
- Latency: a request with pix_valid=1 at edge t produces hit_valid=1 at edge t+2. Throughput is 1 per cycle with no backpressure; pix_valid gaps propagate as hit_valid gaps.
- When hit_valid=0, hit=0. hit_row and hit_col hold their last value.
- Coherence: the shadow registers are read only in stage 1.
  - A pixel accepted on the same edge as frame_start uses the OLD shadow values.
  - Pixels already in stage 2 are unaffected by a shadow load.
- Ball partly off-screen (centre near 0 or near the max coordinate): handled by the signed offsets; the off-screen sprite portion is simply never addressed.
- Reset mid-stream: the edge with reset_L=0 clears all valids. hit_valid=0 the following cycle and no in-flight result emerges. hit=0 until the next frame_start with ball_en=1.

Optional Feature:
- Macro: BALL_OUTLINE_EN
- Defined:
  - Adds output edge (1 bit).
  - Stage 1 additionally registers rows dr-1 and dr+1 (zero when out of range or !in_box).
  - Stage 2: edge = hit && any 4-neighbour bit is 0; neighbours outside the sprite count as 0.
  - edge=0 when hit_valid=0; edge resets to 0.
- Undefined: no edge port, no neighbour rows; area equals the base design.

Decomposition:
- Package sprite_pkg:
  - constants SPRITE_DIM, SPRITE_HALF, COORD_W
  - typedef sprite_t = logic [SPRITE_DIM-1:0][SPRITE_DIM-1:0]
  - typedef coord_t = logic [COORD_W-1:0]
  - typedef offset_t = signed logic [COORD_W+1:0]
- One sub-module: ball_shadow_regs, the frame_start-gated capture of en/x/y/sprite with synchronous active-low reset. The pipeline stays in the top module.

Test Plan:
- Reset, then frame_start with ball_en=1, x=100, y=100, sprite from radius 10.
  - Pixel (100,100) -> hit_valid=1, hit=1 two cycles later.
  - (110,100) -> hit=0, since 100 is not < 100.
  - (109,100) -> hit=1.
- Same ball, pixel (row 37, col 100) -> dr=0 in box, hit=0. Pixels (36,100) and (0,0) -> out of box, hit=0.
- Ball at x=5, y=5, radius 10:
  - Pixel (0,0) -> hit=1 (dist² 50).
  - Pixel (0,1023) -> hit=0 (no wrap).
- Change ball_x to 300 without frame_start -> results unchanged. Pulse frame_start on the same edge as a pixel at (100,100) -> that pixel hits (old centre); pixel (100,300) on the next edge -> hit=1.
- Stream 640 back-to-back pixels of row 100 with random pix_valid gaps -> hit_valid equals pix_valid delayed 2. hit=1 exactly for cols 91..109 (radius 10). Echoes match.
- Reset_L=0 for one edge mid-stream -> hit_valid=0 the next two cycles. After reset, pixel (100,100) -> hit=0 until a new frame_start.
- With BALL_OUTLINE_EN, radius 10 at (100,100):
  - Pixel (100,109) -> hit=1, edge=1.
  - Pixel (100,100) -> hit=1, edge=0.
